// File: rtl/acc_pkg.sv
// Shared opcode, FSM-state and flag-position constants for the accumulator bank.
package acc_pkg;

  localparam logic [3:0] OP_NOP       = 4'd0;
  localparam logic [3:0] OP_LATCH_REG = 4'd1;
  localparam logic [3:0] OP_LATCH_IMM = 4'd2;
  localparam logic [3:0] OP_LOAD_OPND = 4'd3;
  localparam logic [3:0] OP_LOAD_ALU  = 4'd4;
  localparam logic [3:0] OP_CLR       = 4'd5;
  localparam logic [3:0] OP_SHL       = 4'd6;
  localparam logic [3:0] OP_SHR       = 4'd7;
  localparam logic [3:0] OP_INC       = 4'd8;
  localparam logic [3:0] OP_DEC       = 4'd9;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ALU = 1'b1;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // Opcodes that target an accumulator (and therefore need a valid cmd_idx).
  function automatic logic op_writes_acc(input logic [3:0] op);
    return (op >= OP_LOAD_OPND) && (op <= OP_DEC);
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_DEC;
  endfunction

endpackage

// File: rtl/acc_alu_lite.sv
// Per-accumulator next-value logic for the single-cycle opcodes.
module acc_alu_lite
  import acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] old,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             we
);

  always_comb begin
    result = old;
    carry  = 1'b0;
    we     = 1'b0;
    case (op)
      OP_LOAD_OPND: begin result = opnd;       we = 1'b1; end
      OP_CLR:       begin result = '0;         we = 1'b1; end
      OP_SHL:       begin result = old << 1;   carry = old[WIDTH-1]; we = 1'b1; end
      OP_SHR:       begin result = old >> 1;   carry = old[0];       we = 1'b1; end
      OP_INC: begin
        {carry, result} = {1'b0, old} + (WIDTH+1)'(1);
        we = 1'b1;
      end
      OP_DEC: begin
        result = old - WIDTH'(1);
        carry  = (old == '0);
        we     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// Bank of ACC_COUNT accumulators plus operand latch, driven by a valid/ready
// command port, with an ALU write-back that waits (bounded) for alu_valid.
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACC_COUNT   = 4,
  parameter int IMM_W       = 4,
  parameter int ALU_TIMEOUT = 16,
  parameter int IDX_W       = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1
) (
  input  logic             clk,
  input  logic             clb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [IDX_W-1:0] cmd_idx,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [WIDTH-1:0] reg_in,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_valid,
  output logic [WIDTH-1:0] address1,
  output logic [WIDTH-1:0] address2,
  output logic [WIDTH-1:0] accout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout
);

  localparam int                 CNT_W    = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);
  localparam logic [IDX_W:0]     ACC_LIM  = (IDX_W+1)'(ACC_COUNT);

  logic [ACC_COUNT-1:0][WIDTH-1:0] acc;
  logic [WIDTH-1:0]                opnd;
  logic [2:0]                      flags;
  logic [0:0]                      state, state_n;
  logic [CNT_W-1:0]                cnt, cnt_n;
  logic [IDX_W-1:0]                wait_idx, wait_idx_n;
  logic [WIDTH-1:0]                opnd_n;

  logic [ACC_COUNT-1:0][WIDTH-1:0] lane_res;
  logic [ACC_COUNT-1:0]            lane_c, lane_we;

  logic [WIDTH-1:0] rd_val, sel_res;
  logic             sel_c, sel_we;
  logic             accept, cmd_idx_ok;
  logic             wr_en, wr_c, set_ill, set_to;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;

  genvar g;
  generate
    for (g = 0; g < ACC_COUNT; g++) begin : g_lane
      acc_alu_lite #(.WIDTH(WIDTH)) u_lane (
        .op     (cmd_op),
        .old    (acc[g]),
        .opnd   (opnd),
        .result (lane_res[g]),
        .carry  (lane_c[g]),
        .we     (lane_we[g])
      );
    end
  endgenerate

  // Out-of-range indices match no lane, so reads fall through to zero.
  always_comb begin
    rd_val  = '0;
    sel_res = '0;
    sel_c   = 1'b0;
    sel_we  = 1'b0;
    for (int i = 0; i < ACC_COUNT; i++) begin
      if (rd_idx == IDX_W'(i)) rd_val = acc[i];
      if (cmd_idx == IDX_W'(i)) begin
        sel_res = lane_res[i];
        sel_c   = lane_c[i];
        sel_we  = lane_we[i];
      end
    end
  end

  assign accept     = cmd_valid & cmd_ready;
  assign cmd_idx_ok = {1'b0, cmd_idx} < ACC_LIM;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    wait_idx_n = wait_idx;
    opnd_n     = opnd;
    wr_en      = 1'b0;
    wr_idx     = cmd_idx;
    wr_data    = sel_res;
    wr_c       = flags[FLAG_C];
    set_ill    = 1'b0;
    set_to     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_illegal(cmd_op)) begin
            set_ill = 1'b1;
          end else if (cmd_op == OP_LATCH_REG) begin
            opnd_n = reg_in;
          end else if (cmd_op == OP_LATCH_IMM) begin
            opnd_n = WIDTH'(imm);
          end else if (op_writes_acc(cmd_op)) begin
            // A bad target drops the command; LOAD_ALU then never enters the wait.
            if (!cmd_idx_ok) begin
              set_ill = 1'b1;
            end else if (cmd_op == OP_LOAD_ALU) begin
              state_n    = ST_WAIT_ALU;
              wait_idx_n = cmd_idx;
              cnt_n      = '0;
            end else begin
              wr_en = sel_we;
              wr_c  = (cmd_op == OP_LOAD_OPND) ? flags[FLAG_C] : sel_c;
            end
          end
        end
      end
      ST_WAIT_ALU: begin
        // alu_valid takes priority so a result on the last allowed cycle lands.
        if (alu_valid) begin
          wr_en   = 1'b1;
          wr_idx  = wait_idx;
          wr_data = alu_out;
          wr_c    = alu_carry;
          state_n = ST_IDLE;
        end else if (ALU_TIMEOUT != 0 && cnt == CNT_LAST) begin
          set_to  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clb) begin
      acc         <= '0;
      opnd        <= '0;
      flags       <= '0;
      state       <= ST_IDLE;
      cnt         <= '0;
      wait_idx    <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      wait_idx    <= wait_idx_n;
      opnd        <= opnd_n;
      err_illegal <= err_illegal | set_ill;
      err_timeout <= err_timeout | set_to;
      if (wr_en) begin
        for (int i = 0; i < ACC_COUNT; i++)
          if (wr_idx == IDX_W'(i)) acc[i] <= wr_data;
        flags[FLAG_Z] <= (wr_data == '0);
        flags[FLAG_N] <= wr_data[WIDTH-1];
        flags[FLAG_C] <= wr_c;
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_WAIT_ALU);
  assign address1  = opnd;
  assign address2  = rd_val;
  assign accout    = rd_val;
  assign flag_z    = flags[FLAG_Z];
  assign flag_n    = flags[FLAG_N];
  assign flag_c    = flags[FLAG_C];

endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank built with ACC_COUNT=3 (non-power-of-two index space).
module tb_acc_bank;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       clb = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_op = 4'd0;
  logic [1:0] cmd_idx = 2'd0;
  logic [1:0] rd_idx = 2'd0;
  logic [7:0] reg_in = 8'd0;
  logic [3:0] imm = 4'd0;
  logic [7:0] alu_out = 8'd0;
  logic       alu_carry = 1'b0;
  logic       alu_valid = 1'b0;
  logic [7:0] address1, address2, accout;
  logic       flag_z, flag_n, flag_c, busy, err_illegal, err_timeout;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(8), .ACC_COUNT(3), .IMM_W(4), .ALU_TIMEOUT(16), .IDX_W(2)) dut (
    .clk(clk), .clb(clb), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .rd_idx(rd_idx), .reg_in(reg_in),
    .imm(imm), .alu_out(alu_out), .alu_carry(alu_carry), .alu_valid(alu_valid),
    .address1(address1), .address2(address2), .accout(accout),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .busy(busy),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] idx);
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx;
    cyc();
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_idx = 2'd0;
  endtask

  task automatic rd(input logic [1:0] i, output logic [7:0] v);
    rd_idx = i; #1; v = accout;
  endtask

  task automatic test_reset();
    clb = 1'b1; cyc(); cyc(); clb = 1'b0;
    nvec++; if (cmd_ready !== 1'b1) begin nerr++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", busy); end
    nvec++; if (address1 !== 8'h00) begin nerr++; $display("FAIL rst_addr1 got %h exp 00", address1); end
    nvec++; if (accout !== 8'h00) begin nerr++; $display("FAIL rst_accout got %h exp 00", accout); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin nerr++; $display("FAIL rst_flags got %b exp 000", {flag_c, flag_n, flag_z}); end
    nvec++; if ({err_illegal, err_timeout} !== 2'b00) begin nerr++; $display("FAIL rst_errs got %b exp 00", {err_illegal, err_timeout}); end
  endtask

  task automatic test_latch_load();
    logic [7:0] v;
    imm = 4'hA; issue(OP_LATCH_IMM, 2'd0);
    nvec++; if (address1 !== 8'h0A) begin nerr++; $display("FAIL latch_imm got %h exp 0a", address1); end
    issue(OP_LOAD_OPND, 2'd2);
    rd(2'd2, v);
    nvec++; if (v !== 8'h0A) begin nerr++; $display("FAIL load_acc2 got %h exp 0a", v); end
    nvec++; if (address2 !== 8'h0A) begin nerr++; $display("FAIL load_addr2 got %h exp 0a", address2); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin nerr++; $display("FAIL load_flags got %b exp 000", {flag_c, flag_n, flag_z}); end
  endtask

  task automatic test_shift_dec();
    logic [7:0] v;
    reg_in = 8'h80; issue(OP_LATCH_REG, 2'd0);
    nvec++; if (address1 !== 8'h80) begin nerr++; $display("FAIL latch_reg got %h exp 80", address1); end
    issue(OP_LOAD_OPND, 2'd1);
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b010) begin nerr++; $display("FAIL load80_flags got %b exp 010", {flag_c, flag_n, flag_z}); end
    issue(OP_SHL, 2'd1); rd(2'd1, v);
    nvec++; if (v !== 8'h00) begin nerr++; $display("FAIL shl_val got %h exp 00", v); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b101) begin nerr++; $display("FAIL shl_flags got %b exp 101", {flag_c, flag_n, flag_z}); end
    issue(OP_DEC, 2'd1); rd(2'd1, v);
    nvec++; if (v !== 8'hFF) begin nerr++; $display("FAIL dec_val got %h exp ff", v); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b110) begin nerr++; $display("FAIL dec_flags got %b exp 110", {flag_c, flag_n, flag_z}); end
    issue(OP_INC, 2'd1); rd(2'd1, v);
    nvec++; if (v !== 8'h00) begin nerr++; $display("FAIL inc_wrap got %h exp 00", v); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b101) begin nerr++; $display("FAIL inc_flags got %b exp 101", {flag_c, flag_n, flag_z}); end
    issue(OP_SHR, 2'd2); rd(2'd2, v);
    nvec++; if (v !== 8'h05) begin nerr++; $display("FAIL shr_val got %h exp 05", v); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin nerr++; $display("FAIL shr_flags got %b exp 000", {flag_c, flag_n, flag_z}); end
  endtask

  task automatic test_rdw();
    rd_idx = 2'd2;
    cmd_valid = 1'b1; cmd_op = OP_INC; cmd_idx = 2'd2; #1;
    nvec++; if (accout !== 8'h05) begin nerr++; $display("FAIL rdw_old got %h exp 05", accout); end
    cyc(); cmd_valid = 1'b0; cmd_op = OP_NOP;
    nvec++; if (accout !== 8'h06) begin nerr++; $display("FAIL rdw_new got %h exp 06", accout); end
  endtask

  task automatic test_alu_wait();
    logic [7:0] v;
    rd_idx = 2'd0;
    cmd_valid = 1'b1; cmd_op = OP_LOAD_ALU; cmd_idx = 2'd0;
    alu_valid = 1'b1; alu_out = 8'h33; alu_carry = 1'b0;
    cyc();
    cmd_op = OP_CLR; cmd_idx = 2'd2; alu_valid = 1'b0;
    nvec++; if ({cmd_ready, busy} !== 2'b01) begin nerr++; $display("FAIL wait_c1 got %b exp 01", {cmd_ready, busy}); end
    cyc();
    nvec++; if ({cmd_ready, busy} !== 2'b01) begin nerr++; $display("FAIL wait_c2 got %b exp 01", {cmd_ready, busy}); end
    cyc();
    nvec++; if ({cmd_ready, busy} !== 2'b01) begin nerr++; $display("FAIL wait_c3 got %b exp 01", {cmd_ready, busy}); end
    alu_valid = 1'b1; alu_out = 8'h5C; alu_carry = 1'b1;
    cyc();
    alu_valid = 1'b0; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_idx = 2'd0;
    nvec++; if ({cmd_ready, busy} !== 2'b10) begin nerr++; $display("FAIL wait_done got %b exp 10", {cmd_ready, busy}); end
    nvec++; if (accout !== 8'h5C) begin nerr++; $display("FAIL alu_acc0 got %h exp 5c", accout); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b100) begin nerr++; $display("FAIL alu_flags got %b exp 100", {flag_c, flag_n, flag_z}); end
    rd(2'd2, v);
    nvec++; if (v !== 8'h06) begin nerr++; $display("FAIL wait_ignore got %h exp 06", v); end
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    int bad;
    rd_idx = 2'd0; bad = 0;
    issue(OP_LOAD_ALU, 2'd0);
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (busy !== 1'b1 || err_timeout !== 1'b0) bad++;
    end
    nvec++; if (bad !== 0) begin nerr++; $display("FAIL to_early got %0d bad cycles exp 0", bad); end
    cyc();
    nvec++; if ({err_timeout, cmd_ready} !== 2'b11) begin nerr++; $display("FAIL to_expire got %b exp 11", {err_timeout, cmd_ready}); end
    nvec++; if (accout !== 8'h5C) begin nerr++; $display("FAIL to_nowrite got %h exp 5c", accout); end
    issue(OP_LOAD_ALU, 2'd1);
    repeat (15) cyc();
    alu_valid = 1'b1; alu_out = 8'h81; alu_carry = 1'b0;
    cyc(); alu_valid = 1'b0;
    rd(2'd1, v);
    nvec++; if (v !== 8'h81) begin nerr++; $display("FAIL last_cycle_wr got %h exp 81", v); end
    nvec++; if ({cmd_ready, flag_c, flag_n, flag_z} !== 4'b1010) begin nerr++; $display("FAIL last_cycle_st got %b exp 1010", {cmd_ready, flag_c, flag_n, flag_z}); end
  endtask

  task automatic test_illegal_idx();
    logic [7:0] v;
    rd(2'd3, v);
    nvec++; if (v !== 8'h00) begin nerr++; $display("FAIL rd_oob got %h exp 00", v); end
    nvec++; if (err_illegal !== 1'b0) begin nerr++; $display("FAIL ill_pre got %b exp 0", err_illegal); end
    issue(OP_CLR, 2'd3);
    nvec++; if (err_illegal !== 1'b1) begin nerr++; $display("FAIL ill_idx got %b exp 1", err_illegal); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b010) begin nerr++; $display("FAIL ill_flags got %b exp 010", {flag_c, flag_n, flag_z}); end
    rd(2'd0, v);
    nvec++; if (v !== 8'h5C) begin nerr++; $display("FAIL ill_acc0 got %h exp 5c", v); end
    rd(2'd1, v);
    nvec++; if (v !== 8'h81) begin nerr++; $display("FAIL ill_acc1 got %h exp 81", v); end
    rd(2'd2, v);
    nvec++; if (v !== 8'h06) begin nerr++; $display("FAIL ill_acc2 got %h exp 06", v); end
  endtask

  task automatic test_reset_wait();
    logic [7:0] v;
    issue(OP_LOAD_ALU, 2'd2);
    cyc();
    clb = 1'b1; cyc(); clb = 1'b0;
    alu_valid = 1'b1; alu_out = 8'h77; alu_carry = 1'b1;
    cyc(); alu_valid = 1'b0;
    nvec++; if ({cmd_ready, busy} !== 2'b10) begin nerr++; $display("FAIL rstw_state got %b exp 10", {cmd_ready, busy}); end
    nvec++; if ({err_illegal, err_timeout, flag_c, flag_n, flag_z} !== 5'b0) begin nerr++; $display("FAIL rstw_bits got %b exp 00000", {err_illegal, err_timeout, flag_c, flag_n, flag_z}); end
    for (int i = 0; i < 3; i++) begin
      rd(2'(i), v);
      nvec++; if (v !== 8'h00) begin nerr++; $display("FAIL rstw_acc%0d got %h exp 00", i, v); end
    end
  endtask

  task automatic test_illegal_op();
    logic [7:0] v;
    issue(OP_NOP, 2'd0);
    nvec++; if (err_illegal !== 1'b0) begin nerr++; $display("FAIL nop_err got %b exp 0", err_illegal); end
    issue(4'hF, 2'd0);
    nvec++; if ({err_illegal, err_timeout} !== 2'b10) begin nerr++; $display("FAIL ill_op got %b exp 10", {err_illegal, err_timeout}); end
    rd(2'd0, v);
    nvec++; if ({v, address1} !== 16'h0000) begin nerr++; $display("FAIL ill_op_state got %h exp 0000", {v, address1}); end
    nvec++; if ({flag_c, flag_n, flag_z} !== 3'b000) begin nerr++; $display("FAIL ill_op_flags got %b exp 000", {flag_c, flag_n, flag_z}); end
  endtask

  initial begin
    test_reset();
    test_latch_load();
    test_shift_dec();
    test_rdw();
    test_alu_wait();
    test_timeout();
    test_illegal_idx();
    test_reset_wait();
    test_illegal_op();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
